key_timer: RTL and testbench

Parametrised key-entry countdown timer for the DE0 board top level. Four active-low push-buttons enter a binary start value bit-by-bit under a blinking cursor. A start key begins a countdown at a programmable rate. Reaching zero raises a latched beep and a one-cycle done strobe. It replaces the fixed 8-bit, derived-clock timer logic with a single-clock, clock-enabled block that drives LEDR (disp) and a beeper.

---
 rtl/key_timer_pkg.sv | 34 +++
 rtl/key_timer_tick_gen.sv | 33 +++
 rtl/key_timer.sv | 176 +++++++++++++++++
 tb/tb_key_timer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_timer_pkg.sv
// rtl/key_timer_pkg.sv - shared FSM state type, key index constants and key priority helper
//
// Contents:
//   state_t   : IDLE, ENTER, RUN, PAUSE (PAUSE only reachable with KEY_TIMER_PAUSE_EN)
//   K_ZERO .. K_GO : key indices, also used as event codes
//   key_code  : lowest pressed (low) key index of a snapshot
package key_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] K_ZERO = 2'd0;
    localparam logic [1:0] K_ONE  = 2'd1;
    localparam logic [1:0] K_BACK = 2'd2;
    localparam logic [1:0] K_GO   = 2'd3;

    // Keys are active-low; key[0] wins when several are down together.
    function automatic logic [1:0] key_code(input logic [3:0] ks);
        if (!ks[0]) begin
            return K_ZERO;
        end else if (!ks[1]) begin
            return K_ONE;
        end else if (!ks[2]) begin
            return K_BACK;
        end else begin
            return K_GO;
        end
    endfunction

endpackage

// File: rtl/key_timer_tick_gen.sv
// rtl/key_timer_tick_gen.sv - free-running divider producing a one-cycle enable every DIV clocks
//
// Ports:
//   clock   in   system clock
//   reset_n in   asynchronous active-low reset (divider restarts at 0)
//   strobe  out  high for one cycle while the divider sits at DIV-1
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    output logic strobe
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded straight from the counter register: an enable, not a clock.
    assign strobe = (cnt == LAST);

endmodule

// File: rtl/key_timer.sv
// rtl/key_timer.sv - key-entry countdown timer with blinking edit cursor and expiry beep
//
// Optional feature: define KEY_TIMER_PAUSE_EN to add the PAUSE state
// (key3 pauses/resumes a run, key2 in PAUSE restores the start value and returns to ENTER).
//
// Ports:
//   clock    in   system clock (only clock; everything advances on the internal tick enable)
//   reset_n  in   asynchronous active-low reset
//   key      in   [3:0] raw active-low buttons: 0 enter 0, 1 enter 1, 2 cursor back, 3 start
//   disp     out  [WIDTH-1:0] value with the cursor bit blinking while editing
//   value    out  [WIDTH-1:0] counter value
//   cursor   out  [$clog2(WIDTH)-1:0] edit position
//   running  out  high while counting down
//   beep     out  set at expiry, cleared by the next key event
//   done     out  one-cycle strobe at expiry
module key_timer
    import key_timer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 524288,
    parameter int COUNT_DIV  = 256,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [3:0]               key,
    output logic [WIDTH-1:0]         disp,
    output logic [WIDTH-1:0]         value,
    output logic [$clog2(WIDTH)-1:0] cursor,
    output logic                     running,
    output logic                     beep,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CUR_LAST = CW'(WIDTH - 1);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);
    localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                tick;
    logic [3:0]          key_s1;
    logic [3:0]          key_s2;
    logic [3:0]          ks;
    logic [BLINK_LOG2:0] blink_cnt;
    state_t              state;
    logic [WIDTH-1:0]    value_q;
    logic [CW-1:0]       cursor_q;
    logic [PW-1:0]       presc;
    logic                beep_q;
    logic                done_q;
`ifdef KEY_TIMER_PAUSE_EN
    logic [WIDTH-1:0]    reload_q;
`endif

    logic                key_event;
    logic [1:0]          code;
    logic [CW-1:0]       cursor_inc;
    logic [CW-1:0]       cursor_dec;
    logic                blink;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .strobe (tick)
    );

    // ks holds the snapshot from the previous tick; key_s2 is the one being
    // taken now. An event needs all keys up last tick, so a held key fires once.
    assign key_event  = tick && (ks == 4'hF) && (key_s2 != 4'hF);
    assign code       = key_code(key_s2);

    // Explicit wrap so non-power-of-two widths stay in range.
    assign cursor_inc = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
    assign cursor_dec = (cursor_q == '0) ? CUR_LAST : cursor_q - 1'b1;

    assign blink      = blink_cnt[BLINK_LOG2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_s1    <= 4'hF;
            key_s2    <= 4'hF;
            ks        <= 4'hF;
            blink_cnt <= '0;
            state     <= ST_IDLE;
            value_q   <= '0;
            cursor_q  <= '0;
            presc     <= '0;
            beep_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef KEY_TIMER_PAUSE_EN
            reload_q  <= '0;
`endif
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            done_q <= 1'b0;
            if (tick) begin
                ks        <= key_s2;
                blink_cnt <= blink_cnt + 1'b1;
                case (state)
                    ST_IDLE: begin
                        // The waking event is consumed; it does not edit.
                        if (key_event) begin
                            beep_q <= 1'b0;
                            state  <= ST_ENTER;
                        end
                    end
                    ST_ENTER: begin
                        if (key_event) begin
                            if (code == K_ZERO || code == K_ONE) begin
                                value_q[cursor_q] <= code[0];
                                cursor_q          <= cursor_inc;
                            end else if (code == K_BACK) begin
                                cursor_q <= cursor_dec;
                            end else if (value_q == '0) begin
                                beep_q <= 1'b1;
                                done_q <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                presc <= '0;
`ifdef KEY_TIMER_PAUSE_EN
                                reload_q <= value_q;
`endif
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
`ifdef KEY_TIMER_PAUSE_EN
                        if (key_event && code == K_GO) begin
                            state <= ST_PAUSE;
                        end else
`endif
                        if (presc == PRE_LAST) begin
                            presc   <= '0;
                            value_q <= value_q - 1'b1;
                            // Leaving at zero means value can never wrap.
                            if (value_q == ONE_HOT0) begin
                                beep_q <= 1'b1;
                                done_q <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
`ifdef KEY_TIMER_PAUSE_EN
                    ST_PAUSE: begin
                        // Prescaler is left untouched so a resume continues mid-period.
                        if (key_event) begin
                            if (code == K_GO) begin
                                state <= ST_RUN;
                            end else if (code == K_BACK) begin
                                value_q <= reload_q;
                                state   <= ST_ENTER;
                            end
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign value   = value_q;
    assign cursor  = cursor_q;
    assign running = (state == ST_RUN);
    assign beep    = beep_q;
    assign done    = done_q;
    assign disp    = value_q ^ (((state == ST_ENTER) && blink) ? (ONE_HOT0 << cursor_q) : '0);

endmodule

// File: tb/tb_key_timer.sv
// tb/tb_key_timer.sv - randomized scoreboard bench for key_timer against a tick-level reference model
module tb_key_timer;

    localparam int WIDTH      = 8;
    localparam int TICK_DIV   = 4;
    localparam int COUNT_DIV  = 3;
    localparam int BLINK_LOG2 = 1;

    localparam int S_IDLE  = 0;
    localparam int S_ENTER = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic [3:0]       key     = 4'hF;
    logic [WIDTH-1:0] disp;
    logic [WIDTH-1:0] value;
    logic [2:0]       cursor;
    logic             running;
    logic             beep;
    logic             done;

    always #5 clock = ~clock;

    key_timer #(
        .WIDTH     (WIDTH),
        .TICK_DIV  (TICK_DIV),
        .COUNT_DIV (COUNT_DIV),
        .BLINK_LOG2(BLINK_LOG2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .key    (key),
        .disp   (disp),
        .value  (value),
        .cursor (cursor),
        .running(running),
        .beep   (beep),
        .done   (done)
    );

    // Observation: {disp, value, cursor, running, beep, done}
    typedef logic [21:0] obs_t;

    obs_t exp_q[$];
    obs_t last_pushed = '0;
    obs_t mon_last    = '0;
    int   n_checks    = 0;
    int   n_errors    = 0;

    int         m_state;
    logic [7:0] m_val;
    logic [7:0] m_reload;
    int         m_cur;
    int         m_presc;
    int         m_ticks;
    logic       m_beep;
    logic [3:0] m_prev;

    function automatic obs_t model_obs(input logic dn);
        logic [7:0] d;
        d = m_val;
        if (m_state == S_ENTER && ((m_ticks >> BLINK_LOG2) & 1) == 1)
            d = m_val ^ (8'd1 << m_cur);
        return {d, m_val, 3'(m_cur), (m_state == S_RUN), m_beep, dn};
    endfunction

    task automatic push_obs(input bit dn_pulse);
        obs_t o;
        if (dn_pulse) begin
            exp_q.push_back(model_obs(1'b1));
            last_pushed = model_obs(1'b0);
            exp_q.push_back(last_pushed);
        end else begin
            o = model_obs(1'b0);
            if (o !== last_pushed) begin
                exp_q.push_back(o);
                last_pushed = o;
            end
        end
    endtask

    task automatic model_reset();
        m_state  = S_IDLE;
        m_val    = '0;
        m_reload = '0;
        m_cur    = 0;
        m_presc  = 0;
        m_ticks  = 0;
        m_beep   = 1'b0;
        m_prev   = 4'hF;
        push_obs(1'b0);
    endtask

    // One tick of the reference: k is the key pattern held through the tick period.
    task automatic model_tick(input logic [3:0] k);
        bit ev;
        bit dn;
        int c;
        m_ticks++;
        ev = (m_prev == 4'hF) && (k != 4'hF);
        c  = 3;
        for (int i = 3; i >= 0; i--) if (!k[i]) c = i;
        m_prev = k;
        dn = 0;
        case (m_state)
            S_IDLE: if (ev) begin
                m_beep  = 1'b0;
                m_state = S_ENTER;
            end
            S_ENTER: if (ev) begin
                if (c <= 1) begin
                    m_val[m_cur] = c[0];
                    m_cur = (m_cur + 1) % WIDTH;
                end else if (c == 2) begin
                    m_cur = (m_cur + WIDTH - 1) % WIDTH;
                end else if (m_val == 0) begin
                    m_beep = 1'b1; dn = 1; m_state = S_IDLE;
                end else begin
                    m_presc = 0; m_reload = m_val; m_state = S_RUN;
                end
            end
            S_RUN: begin
`ifdef KEY_TIMER_PAUSE_EN
                if (ev && c == 3) m_state = S_PAUSE;
                else
`endif
                if (m_presc == COUNT_DIV - 1) begin
                    m_presc = 0;
                    m_val   = m_val - 8'd1;
                    if (m_val == 0) begin
                        m_beep = 1'b1; dn = 1; m_state = S_IDLE;
                    end
                end else begin
                    m_presc++;
                end
            end
            default: if (ev) begin
                if (c == 3) m_state = S_RUN;
                else if (c == 2) begin
                    m_val = m_reload; m_state = S_ENTER;
                end
            end
        endcase
        push_obs(dn);
    endtask

    // Monitor: every change of the observed outputs must match the next expected observation.
    always @(negedge clock) begin
        obs_t cur;
        obs_t e;
        cur = {disp, value, cursor, running, beep, done};
        if (cur !== mon_last) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_change: got %h expected no change from %h", cur, mon_last);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard: got %h expected %h at %0t", cur, e, $time);
                end
            end
            mon_last = cur;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hold k for one whole tick period; the DUT samples it on the closing tick.
    task automatic do_tick(input logic [3:0] k);
        @(negedge clock);
        key = k;
        repeat (TICK_DIV) @(posedge clock);
        model_tick(k);
    endtask

    task automatic press(input int c);
        logic [3:0] kk;
        kk    = 4'hF;
        kk[c] = 1'b0;
        do_tick(kk);
        do_tick(4'hF);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic enter_value(input logic [7:0] v);
        for (int i = 0; i < WIDTH; i++) press(int'(v[m_cur]));
    endtask

    task automatic to_enter();
        int guard;
        guard = 0;
        while (m_state == S_RUN && guard < 3000) begin
            do_tick(4'hF);
            guard++;
        end
        if (m_state == S_PAUSE) press(2);
        if (m_state == S_IDLE) press(0);
    endtask

    initial begin
        int r;
        int guard;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        chk("reset_value", value, 0);
        chk("reset_cursor", cursor, 0);
        chk("reset_running", running, 0);
        chk("reset_beep", beep, 0);
        chk("reset_done", done, 0);
        chk("reset_disp", disp, 0);

        press($urandom_range(0, 3));
        #1;
        chk("wake_beep", beep, 0);
        chk("wake_value", value, 0);

        press(1); press(0); press(1);
        #1;
        chk("enter101_value", value, 8'h05);
        chk("enter101_cursor", cursor, 3);

        press(2); press(2); press(2);
        press(2);
        #1;
        chk("back_wrap_cursor", cursor, 7);

        repeat (20) do_tick(4'b1101);
        do_tick(4'hF);
        #1;
        chk("hold_value", value, 8'h85);
        chk("hold_cursor", cursor, 0);

        enter_value(8'h03);
        press(3);
        repeat (7) do_tick(4'hF);
        #1;
        chk("run_value", value, 1);
        chk("run_running", running, 1);
        do_tick(4'hF);
        #1;
        chk("expire_done", done, 1);
        chk("expire_beep", beep, 1);
        chk("expire_running", running, 0);
        do_tick(4'hF);
        #1;
        chk("expire_done_low", done, 0);

        press(3);
        #1;
        chk("wake_clears_beep", beep, 0);
        do_tick(4'b0111);
        #1;
        chk("zero_start_done", done, 1);
        chk("zero_start_beep", beep, 1);
        do_tick(4'hF);
        press(0);
        #1;
        chk("event_clears_beep", beep, 0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) press($urandom_range(0, 1));
            else if (r == 4) press(2);
            else if (r == 5) press(3);
            else if (r == 6) begin
                logic [3:0] kk;
                kk = 4'hF;
                kk[$urandom_range(0, 3)] = 1'b0;
                repeat ($urandom_range(1, 5)) do_tick(kk);
                do_tick(4'hF);
            end else begin
                repeat ($urandom_range(1, 6)) do_tick(4'hF);
            end
        end
        guard = 0;
        while (m_state == S_RUN && guard < 3000) begin
            do_tick(4'hF);
            guard++;
        end
        #1;
        chk("drain_running", running, 0);

        to_enter();
        enter_value(8'h02);
        press(3);
        #1;
        chk("prereset_value", value, 2);
        chk("prereset_running", running, 1);
        key = 4'hF;
        @(negedge clock);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_value", value, 0);
        chk("midreset_running", running, 0);
        chk("midreset_cursor", cursor, 0);
        chk("midreset_disp", disp, 0);
        repeat (3) @(posedge clock);
        release_reset();
        repeat (10) do_tick(4'hF);
        #1;
        chk("postreset_done", done, 0);
        chk("postreset_beep", beep, 0);

`ifdef KEY_TIMER_PAUSE_EN
        to_enter();
        enter_value(8'h05);
        press(3);
        press(3);
        #1;
        chk("pause_running", running, 0);
        chk("pause_value", value, 5);
        repeat (30) do_tick(4'hF);
        #1;
        chk("pause_frozen", value, 5);
        press(3);
        repeat (6) do_tick(4'hF);
        #1;
        chk("resume_running", running, 1);
        press(3);
        press(2);
        #1;
        chk("restore_value", value, 5);
        chk("restore_running", running, 0);
`endif

        repeat (3) do_tick(4'hF);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
